frame_ram_arbiter: RTL

- Shares the single-port frame-buffer RAM between two requesters: the SD loader (write) and the VGA fetcher (read).
- The reader has priority because of the display deadline. A run-length guard stops the reader from starving the writer.
- The grant is combinational, so each requester can issue one access per cycle. RAM control is registered, and read data comes back with a fixed-latency valid strobe.
- Sits between the SD read sequencer / VGA pixel fetch and the frame RAM block.

---
 rtl/frame_ram_pkg.sv | 17 +
 rtl/arb_valid_pipe.sv | 26 ++
 rtl/frame_ram_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/frame_ram_pkg.sv
// Shared constants for the frame-buffer datapath: arbiter state encoding and
// frame geometry used by the arbiter, SD sequencer and VGA fetcher.
package frame_ram_pkg;

  typedef enum logic {
    RD_PRIO  = 1'b0,
    WR_FORCE = 1'b1
  } arb_state_e;

  localparam int FRAME_W         = 640;
  localparam int FRAME_H         = 480;
  localparam int WORDS_PER_FRAME = FRAME_W * FRAME_H;

  // Wide enough for the largest allowed reader run length (255).
  localparam int RUN_CNT_W = 8;

endpackage

// File: rtl/arb_valid_pipe.sv
// Read-valid delay line: a read acked in cycle N shows up on valid_o in
// cycle N+DEPTH. Async clear drops every read still in flight.
module arb_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic valid_i,
  output logic valid_o,
  output logic any_o
);

  logic [DEPTH-1:0] stage_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], valid_i};
    end
  end

  assign valid_o = stage_q[DEPTH-1];
  assign any_o   = |stage_q;

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: VGA reader has priority, SD writer is forced
// through after MAX_RD_RUN contested reads. Optional counters: FRAME_ARB_STAT_EN.
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int RAM_RD_LAT = 1,
  parameter int MAX_RD_RUN = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
`ifdef FRAME_ARB_STAT_EN
  ,
  output logic [31:0]       stat_conflicts,
  output logic [31:0]       stat_forced
`endif
);

  localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(MAX_RD_RUN - 1);

  arb_state_e           state_q, state_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic                 ram_ena_q, ram_wena_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic [DATA_W-1:0]    ram_din_q;
  logic                 rd_inflight;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= RD_PRIO;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Grant is combinational so each side can be served every cycle.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    rd_ack    = 1'b0;
    wr_ack    = 1'b0;
    case (state_q)
      RD_PRIO: begin
        if (rd_req) begin
          rd_ack = 1'b1;
          if (wr_req) begin
            run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
            if (run_cnt_q == RUN_LAST) begin
              state_d = WR_FORCE;
            end
          end else begin
            run_cnt_d = '0;
          end
        end else begin
          wr_ack    = wr_req;
          run_cnt_d = '0;
        end
      end
      WR_FORCE: begin
        wr_ack    = wr_req;
        run_cnt_d = '0;
        state_d   = RD_PRIO;
      end
      default: begin
        state_d   = RD_PRIO;
        run_cnt_d = '0;
      end
    endcase
  end

  // Address and write data hold their last value when nothing is granted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram_ena_q  <= 1'b0;
      ram_wena_q <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      ram_ena_q  <= rd_ack | wr_ack;
      ram_wena_q <= wr_ack;
      if (wr_ack) begin
        ram_addr_q <= wr_addr;
        ram_din_q  <= wr_data;
      end else if (rd_ack) begin
        ram_addr_q <= rd_addr;
      end
    end
  end

  arb_valid_pipe #(
    .DEPTH(1 + RAM_RD_LAT)
  ) u_valid_pipe (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .valid_i  (rd_ack),
    .valid_o  (rd_valid),
    .any_o    (rd_inflight)
  );

  assign ram_ena  = ram_ena_q;
  assign ram_wena = ram_wena_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign rd_data  = ram_dout;
  assign busy     = ram_ena_q | rd_inflight;

`ifdef FRAME_ARB_STAT_EN
  logic [31:0] stat_conflicts_q, stat_forced_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_conflicts_q <= '0;
      stat_forced_q    <= '0;
    end else begin
      if (rd_req && wr_req && (stat_conflicts_q != 32'hFFFF_FFFF)) begin
        stat_conflicts_q <= stat_conflicts_q + 32'd1;
      end
      if ((state_q == WR_FORCE) && wr_ack && (stat_forced_q != 32'hFFFF_FFFF)) begin
        stat_forced_q <= stat_forced_q + 32'd1;
      end
    end
  end

  assign stat_conflicts = stat_conflicts_q;
  assign stat_forced    = stat_forced_q;
`endif

endmodule
